operand_fetch_stage: RTL and testbench

- Register-file and operand-select stage that sits directly upstream of the ALU.
- Holds a 2**ADDR_WIDTH x DATA_WIDTH register file with two read ports and one writeback port.
- Selects operand B from register rs2 or from the immediate, then registers the A/B operands, ALU control and destination tag into a single output slot.
- The slot uses a valid/ready handshake toward the ALU, with 1-cycle latency and back-pressure.

---
 rtl/operand_fetch_stage.sv | 86 ++++++++
 tb/tb_operand_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 2R/1W register file with writeback bypass, operand-B
// select, and a single registered output slot feeding the ALU.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  use_imm,
  input  logic [CTRL_WIDTH-1:0] alu_control_in,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [CTRL_WIDTH-1:0] alu_control_out,
  output logic [ADDR_WIDTH-1:0] rd_out
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. A producer holding valid must keep its payload stable until the
  // transfer; ready may depend on the consumer's ready but never on valid.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e state_dbg;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  fire_in;
  logic                  wb_live;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic [DATA_WIDTH-1:0] op_b;

  assign valid_out = (state_dbg == S_FULL);
  assign ready_out = !valid_out || ready_in;
  assign fire_in   = valid_in && ready_out;
  assign wb_live   = wb_en && (wb_addr != '0);

  // Index 0 reads as zero; a same-cycle writeback to the read index wins.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs1 != '0) rd_a = (wb_live && wb_addr == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0) rd_b = (wb_live && wb_addr == rs2) ? wb_data : regs[rs2];
    op_b = use_imm ? imm : rd_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      state_dbg       <= S_EMPTY;
      a_out           <= '0;
      b_out           <= '0;
      alu_control_out <= '0;
      rd_out          <= '0;
    end else begin
      if (wb_live) regs[wb_addr] <= wb_data;
      if (fire_in) begin
        a_out           <= rd_a;
        b_out           <= op_b;
        alu_control_out <= alu_control_in;
        rd_out          <= rd_in;
      end
      case (state_dbg)
        S_EMPTY: if (fire_in) state_dbg <= S_FULL;
        S_FULL:  if (!fire_in && ready_in) state_dbg <= S_EMPTY;
        default: state_dbg <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, writeback/read, bypass, x0,
// immediate select, back-pressure, throughput and reset during a stall.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  rs1, rs2, rd_in;
  logic [31:0] imm;
  logic        use_imm;
  logic [3:0]  alu_control_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] a_out, b_out;
  logic [3:0]  alu_control_out;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_b;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .imm(imm), .use_imm(use_imm),
    .alu_control_in(alu_control_in), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_out(valid_out), .ready_in(ready_in),
    .a_out(a_out), .b_out(b_out), .alu_control_out(alu_control_out),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [31:0] im, input logic ui, input logic [3:0] ctl);
    valid_in = 1'b1; rs1 = r1; rs2 = r2; rd_in = rd;
    imm = im; use_imm = ui; alu_control_in = ctl;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    rs1 = '0; rs2 = '0; rd_in = '0; imm = '0; use_imm = 1'b0; alu_control_in = '0;
    wb(1'b0, 5'd0, 32'd0);

    // Random traffic, then reset for 2 cycles
    for (int i = 0; i < 10; i++) begin
      wb(1'b1, 5'($urandom_range(1, 31)), $urandom);
      issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      ready_in = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_a", a_out, 32'd0);
    check("rst_b", b_out, 32'd0);
    check("rst_ctl", {28'd0, alu_control_out}, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b1; ready_in = 1'b1; wb(1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 32; i++) begin
      issue(5'(i), 5'(i), 5'd0, 32'd0, 1'b0, 4'd0);
      step();
      check("rst_reg_a", a_out, 32'd0);
      check("rst_reg_b", b_out, 32'd0);
    end
    valid_in = 1'b0;
    step();
    check("drain_valid", {31'd0, valid_out}, 32'd0);

    // Write then read
    wb(1'b1, 5'd5, 32'h0000_00AA);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd5, 5'd0, 5'd9, 32'd0, 1'b0, 4'b0010);
    step();
    check("wr_valid", {31'd0, valid_out}, 32'd1);
    check("wr_a", a_out, 32'h0000_00AA);
    check("wr_b", b_out, 32'd0);
    check("wr_ctl", {28'd0, alu_control_out}, 32'h2);
    check("wr_rd", {27'd0, rd_out}, 32'd9);
    valid_in = 1'b0;
    step();
    check("wr_drain_valid", {31'd0, valid_out}, 32'd0);
    check("wr_drain_hold_a", a_out, 32'h0000_00AA);

    // Bypass on both ports, then writes to x0 are ignored
    wb(1'b1, 5'd7, 32'h0000_1234);
    issue(5'd7, 5'd7, 5'd3, 32'd0, 1'b0, 4'd1);
    step();
    check("byp_a", a_out, 32'h0000_1234);
    check("byp_b", b_out, 32'h0000_1234);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 5'd3, 32'd0, 1'b0, 4'd1);
    step();
    check("x0_byp_a", a_out, 32'd0);
    check("x0_byp_b", b_out, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd0, 5'd7, 5'd3, 32'd0, 1'b0, 4'd1);
    step();
    check("x0_read_a", a_out, 32'd0);
    check("r7_stored_b", b_out, 32'h0000_1234);

    // Immediate select ignores rs2
    valid_in = 1'b0;
    wb(1'b1, 5'd3, 32'h0000_0010);
    step();
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd3, 5'd3, 5'd4, 32'hFFFF_FFF0, 1'b1, 4'd5);
    step();
    check("imm_a", a_out, 32'h0000_0010);
    check("imm_b", b_out, 32'hFFFF_FFF0);

    // Back-pressure: fill the slot, stall 3 cycles with a writeback to rs1
    issue(5'd5, 5'd3, 5'd1, 32'd0, 1'b0, 4'd7);
    step();
    check("bp_fill_a", a_out, 32'h0000_00AA);
    check("bp_fill_b", b_out, 32'h0000_0010);
    ready_in = 1'b0;
    issue(5'd5, 5'd0, 5'd2, 32'd0, 1'b0, 4'd8);
    wb(1'b1, 5'd5, 32'h0000_BEEF);
    #1;
    check("bp_ready_out", {31'd0, ready_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", {31'd0, valid_out}, 32'd1);
      check("bp_ready", {31'd0, ready_out}, 32'd0);
      check("bp_hold_a", a_out, 32'h0000_00AA);
      check("bp_hold_b", b_out, 32'h0000_0010);
      check("bp_hold_ctl", {28'd0, alu_control_out}, 32'h7);
      check("bp_hold_rd", {27'd0, rd_out}, 32'd1);
    end
    wb(1'b0, 5'd0, 32'd0);
    ready_in = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, ready_out}, 32'd1);
    step();
    check("bp_new_valid", {31'd0, valid_out}, 32'd1);
    check("bp_new_a", a_out, 32'h0000_BEEF);
    check("bp_new_b", b_out, 32'd0);
    check("bp_new_ctl", {28'd0, alu_control_out}, 32'h8);
    check("bp_new_rd", {27'd0, rd_out}, 32'd2);

    // Throughput: 8 back-to-back issues
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 32'h11 + 1));
    for (int k = 0; k < 8; k++) begin
      issue(5'd0, 5'd0, 5'(k + 1), 32'(k * 32'h11 + 1), 1'b1, 4'(k));
      step();
      exp_b = exp_q.pop_front();
      check("tp_valid", {31'd0, valid_out}, 32'd1);
      check("tp_b", b_out, exp_b);
      check("tp_rd", {27'd0, rd_out}, 32'(k + 1));
    end

    // Reset during a stall discards the held slot
    ready_in = 1'b0;
    issue(5'd7, 5'd7, 5'd6, 32'd0, 1'b0, 4'd3);
    step();
    check("st_valid", {31'd0, valid_out}, 32'd1);
    check("st_hold_b", b_out, 32'h0000_0078);
    reset = 1'b0;
    step();
    check("st_rst_valid", {31'd0, valid_out}, 32'd0);
    check("st_rst_b", b_out, 32'd0);
    check("st_rst_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b1; valid_in = 1'b0;
    step();
    check("st_post_valid", {31'd0, valid_out}, 32'd0);
    ready_in = 1'b1;
    issue(5'd7, 5'd5, 5'd0, 32'd0, 1'b0, 4'd0);
    step();
    check("st_post_r7", a_out, 32'd0);
    check("st_post_r5", b_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
